mdu_hilo: RTL
=============

Name: mdu_hilo

Overview:
- Iterative signed multiply/divide unit with architectural HI/LO registers.
- Consumes the 4-bit ALU control code from the ALU control decoder:
  - 1101 mult
  - 1000 div
  - 1111 mfhi
  - 1011 mflo
- Sits beside the main ALU in EX.
- Raises a stall toward the pipeline while an operation is in flight.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W = WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- alu_ctr  in  4  ALU control code from the decoder.
- start  in  1  EX-stage instruction valid; qualifies alu_ctr for mult/div.
- flush  in  1  abort the in-flight operation.
- op_a  in  WIDTH  rs value (multiplicand/dividend).
- op_b  in  WIDTH  rt value (multiplier/divisor).
- busy  out  1  operation in progress (RUN or FIN).
- done  out  1  one-cycle pulse in FIN.
- div_zero  out  1  divide-by-zero; valid only while done=1.
- stall  out  1  pipeline hold request.
- rd_data  out  WIDTH  mfhi/mflo read data.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; hi, lo, counter and datapath registers = 0; busy=done=div_zero=stall=0.
- Accept: start=1, state=IDLE, alu_ctr ∈ {1101, 1000} → latch |op_a|, |op_b| and result sign bits at that edge.
  - start while busy, or with any other code, is ignored.
- States:
  - IDLE: on accept, go to RUN with cnt=0. Exception: div with op_b=0 goes directly to FIN with div_zero=1.
  - RUN: one radix-2 step per cycle.
    - mult: shift-add into a 2*WIDTH accumulator.
    - div: restoring; shift remainder, trial subtract, set quotient bit.
    - cnt increments each cycle; after cnt=WIDTH-1 go to FIN (exactly WIDTH RUN cycles).
  - FIN: done=1; sign fixup.
    - Product negated if sign(a)^sign(b).
    - Quotient negated if sign(a)^sign(b).
    - Remainder takes the sign of the dividend.
    - At the edge leaving FIN: mult writes hi=product[2W-1:W], lo=product[W-1:0]; div writes lo=quotient, hi=remainder.
    - div_zero case: hi and lo unchanged.
    - Next state IDLE.
- Latency:
  - mult/div: busy high for WIDTH+1 cycles (33 by default); new HI/LO visible the cycle after done.
  - Divide by zero: busy for 1 cycle.
- Overflow: -2^31 / -1 → lo=0x80000000, hi=0; no flag.
- rd_data (combinational): hi when alu_ctr=1111, lo when alu_ctr=1011, else 0.
  - While busy, rd_data shows the old HI/LO; stall blocks its use.
- stall (combinational) = busy & (alu_ctr ∈ {1111, 1011, 1101, 1000}) & start.
  - Also 1 in the IDLE accept cycle (start & mult/div code) so the issuing instruction holds for the whole op.
  - Falls in the cycle after FIN.
- flush=1 in RUN or FIN: return to IDLE next edge; hi/lo unchanged; done suppressed. flush in IDLE has no effect.
- Reset mid-operation: immediate IDLE, hi=lo=0.
- Widths: internal accumulators WIDTH+1 / 2*WIDTH bits; no truncation before fixup.

Optional Feature:
- Macro MDU_MTHILO_EN.
- Defined:
  - Adds inputs mthi_we (1), mtlo_we (1) and wdata (WIDTH).
  - In IDLE, mthi_we/mtlo_we write wdata to hi/lo at the next edge; both may write in the same cycle.
  - While busy, writes are ignored and stall=1 if either we is high.
  - An accepted mult/div in the same cycle takes priority; the write is dropped.
- Undefined: ports absent; HI/LO written only by mult/div.

Test Plan:
- mult 7 × 0xFFFFFFFD (-3) → busy 33 cycles, done 1 cycle, then hi=0xFFFFFFFF, lo=0xFFFFFFEB; mfhi rd_data=0xFFFFFFFF.
- mult 0x80000000 × 0x80000000 → hi=0x40000000, lo=0x00000000.
- div 0xFFFFFFF9 (-7) / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF; then div 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- Preload hi=0x12345678 via a mult; div 5/0 → done and div_zero on the cycle after accept, busy 1 cycle, hi/lo unchanged.
- Hazards and aborts:
  - Issue mult, then mflo with start=1 at cycle 5 → stall=1 until the cycle after FIN.
  - Repeat with flush at cycle 10 → IDLE, no done, hi/lo unchanged.
  - Repeat with rst_n=0 at cycle 10 → hi=lo=0, busy=0 immediately.
- MDU_MTHILO_EN: mthi wdata=0xA5A5A5A5 in IDLE → hi=0xA5A5A5A5 next cycle; mtlo during busy → ignored, stall=1.

Source files
------------

// File: rtl/mdu_hilo.sv
`default_nettype none
// ============================================================================
// Module   : mdu_hilo
// Function : Iterative signed multiply/divide unit with HI/LO registers;
//            optional mthi/mtlo write port enabled by macro MDU_MTHILO_EN.
// Revision : 1.0
// ============================================================================
module mdu_hilo #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       alu_ctr,
   input  logic             start,
   input  logic             flush,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
`ifdef MDU_MTHILO_EN
   input  logic             mthi_we,
   input  logic             mtlo_we,
   input  logic [WIDTH-1:0] wdata,
`endif
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic             stall,
   output logic [WIDTH-1:0] rd_data,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam logic [3:0]       c_op_mult = 4'b1101;
   localparam logic [3:0]       c_op_div  = 4'b1000;
   localparam logic [3:0]       c_op_mfhi = 4'b1111;
   localparam logic [3:0]       c_op_mflo = 4'b1011;
   localparam logic [CNT_W-1:0] c_last    = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIN  = 2'd2
   } state_t;

   state_t             r_state, w_next;
   logic [CNT_W-1:0]   r_cnt;
   logic [2*WIDTH-1:0] r_acc;
   logic [WIDTH-1:0]   r_m;
   logic [WIDTH-1:0]   r_hi, r_lo;
   logic               r_is_div, r_neg, r_sa, r_dz;

   logic               w_is_mult, w_is_div, w_is_mfhi, w_is_mflo;
   logic               w_accept, w_wr_res, w_mt_stall;
   logic [WIDTH-1:0]   w_abs_a, w_abs_b;
   logic [WIDTH:0]     w_sum, w_shift, w_trial;
   logic [2*WIDTH-1:0] w_mul_step, w_div_step, w_prod;
   logic [WIDTH-1:0]   w_quot, w_rem;

   assign w_is_mult = (alu_ctr == c_op_mult);
   assign w_is_div  = (alu_ctr == c_op_div);
   assign w_is_mfhi = (alu_ctr == c_op_mfhi);
   assign w_is_mflo = (alu_ctr == c_op_mflo);
   assign w_accept  = start & (r_state == ST_IDLE) & (w_is_mult | w_is_div);

   assign w_abs_a = op_a[WIDTH-1] ? -op_a : op_a;
   assign w_abs_b = op_b[WIDTH-1] ? -op_b : op_b;

   // Multiply: r_acc = {partial product, remaining multiplier bits}
   assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_m} : '0);
   assign w_mul_step = {w_sum, r_acc[WIDTH-1:1]};

   // Divide: r_acc = {remainder, dividend bits shifting into quotient}
   assign w_shift    = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
   assign w_trial    = w_shift - {1'b0, r_m};
   assign w_div_step = w_trial[WIDTH] ? {w_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                      : {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

   assign w_prod = r_neg ? -r_acc : r_acc;
   assign w_quot = r_neg ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
   assign w_rem  = r_sa  ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

   assign w_wr_res = (r_state == ST_FIN) & ~flush & ~r_dz;

`ifdef MDU_MTHILO_EN
   assign w_mt_stall = busy & (mthi_we | mtlo_we);
`else
   assign w_mt_stall = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: if (w_accept) w_next = (w_is_div && op_b == '0) ? ST_FIN : ST_RUN;
         ST_RUN:  if (flush) w_next = ST_IDLE;
                  else if (r_cnt == c_last) w_next = ST_FIN;
         ST_FIN:  w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   always_comb begin
      busy     = (r_state != ST_IDLE);
      done     = (r_state == ST_FIN) & ~flush;
      div_zero = done & r_dz;
      stall    = (busy & start & (w_is_mult | w_is_div | w_is_mfhi | w_is_mflo))
                 | w_accept | w_mt_stall;
      rd_data  = w_is_mfhi ? r_hi : (w_is_mflo ? r_lo : '0);
      hi       = r_hi;
      lo       = r_lo;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt    <= '0;
         r_acc    <= '0;
         r_m      <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_is_div <= 1'b0;
         r_neg    <= 1'b0;
         r_sa     <= 1'b0;
         r_dz     <= 1'b0;
      end else begin
         if (w_accept) begin
            r_cnt    <= '0;
            r_is_div <= w_is_div;
            r_neg    <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
            r_sa     <= op_a[WIDTH-1];
            r_dz     <= w_is_div & (op_b == '0);
            r_m      <= w_is_div ? w_abs_b : w_abs_a;
            r_acc    <= {{WIDTH{1'b0}}, (w_is_div ? w_abs_a : w_abs_b)};
         end else if (r_state == ST_RUN) begin
            r_cnt <= r_cnt + CNT_W'(1);
            r_acc <= r_is_div ? w_div_step : w_mul_step;
         end

         if (w_wr_res) begin
            if (r_is_div) begin
               r_lo <= w_quot;
               r_hi <= w_rem;
            end else begin
               r_hi <= w_prod[2*WIDTH-1:WIDTH];
               r_lo <= w_prod[WIDTH-1:0];
            end
         end
`ifdef MDU_MTHILO_EN
         else if (r_state == ST_IDLE && !w_accept) begin
            if (mthi_we) r_hi <= wdata;
            if (mtlo_we) r_lo <= wdata;
         end
`endif
      end
   end

endmodule
`default_nettype wire
